// File: rtl/instruction_cache_filler.sv
// Line-fill engine: fetches one aligned instruction line from external memory
// word by word and writes each word into the instruction cache.
module instruction_cache_filler #(
    parameter int LINE_WORDS = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fill_req,
    input  logic [15:0] fill_base,
    input  logic        fill_abort,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        fill_error,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    input  logic        ext_ready,
    input  logic [15:0] ext_data,
    output logic [15:0] mem_offset,
    output logic [5:0]  mem_inst_addr,
    output logic [15:0] mem_inst_bus,
    output logic        mem_we,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [15:0] LINE_MASK = 16'(LINE_WORDS - 1);
    localparam logic [5:0]  LAST_IDX  = 6'(LINE_WORDS - 1);
    localparam logic [7:0]  TIMEOUT_W = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [5:0]  index_q, index_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] bus_q, bus_d;
    logic [5:0]  waddr_q, waddr_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            index_q <= '0;
            wait_q  <= '0;
            bus_q   <= '0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            index_q <= index_d;
            wait_q  <= wait_d;
            bus_q   <= bus_d;
            waddr_q <= waddr_d;
            busy_q  <= busy_d;
        end
    end

    // Handshake: a read completes in any cycle where ext_rd and ext_ready are both
    // high; an abort in the same cycle wins and the returned word is dropped.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        index_d = index_q;
        wait_d  = wait_q;
        bus_d   = bus_q;
        waddr_d = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (fill_req) begin
                    base_d  = fill_base & ~LINE_MASK;
                    index_d = '0;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fill_abort) begin
                    state_d = S_IDLE;
                end else if (ext_ready) begin
                    bus_d   = ext_data;
                    waddr_d = index_q;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q + 8'd1 == TIMEOUT_W) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                if (fill_abort) begin
                    state_d = S_IDLE;
                end else if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 6'd1;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_REQ) || (state_d == S_WRITE);
    end

    // Base is line-aligned, so base + index never carries out of 16 bits.
    assign ext_addr      = base_q + {10'b0, index_q};
    assign ext_rd        = (state_q == S_REQ);
    assign mem_we        = (state_q == S_WRITE);
    assign fill_done     = (state_q == S_DONE);
    assign fill_error    = (state_q == S_ERR);
    assign fill_busy     = busy_q;
    assign mem_offset    = base_q;
    assign mem_inst_addr = waddr_q;
    assign mem_inst_bus  = bus_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instruction_cache_filler.sv
// Bench for instruction_cache_filler: memory responder with per-word wait table,
// write scoreboard fed by a line-level fill model, table vectors and corner sequences.
module tb_instruction_cache_filler;

    localparam int LW = 64;
    localparam int TO = 8;
    localparam logic [15:0] AMASK = ~16'(LW - 1);

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fill_req;
    logic [15:0] fill_base;
    logic        fill_abort;
    logic        fill_busy;
    logic        fill_done;
    logic        fill_error;
    logic [15:0] ext_addr;
    logic        ext_rd;
    logic        ext_ready = 1'b0;
    logic [15:0] ext_data = 16'h0;
    logic [15:0] mem_offset;
    logic [5:0]  mem_inst_addr;
    logic [15:0] mem_inst_bus;
    logic        mem_we;
    logic [2:0]  dbg_state;

    instruction_cache_filler #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .fill_req(fill_req), .fill_base(fill_base), .fill_abort(fill_abort),
        .fill_busy(fill_busy), .fill_done(fill_done), .fill_error(fill_error),
        .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_ready(ext_ready), .ext_data(ext_data),
        .mem_offset(mem_offset), .mem_inst_addr(mem_inst_addr),
        .mem_inst_bus(mem_inst_bus), .mem_we(mem_we), .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory responder: ready on the wait_tbl[word]-th consecutive REQ cycle (0 = never)
    int wait_tbl[LW];
    int req_cnt = 0;
    always @(negedge clock) begin
        if (ext_rd) req_cnt++;
        else req_cnt = 0;
        ext_data  = ext_addr ^ 16'hA5A5;
        ext_ready = ext_rd && (wait_tbl[ext_addr[5:0]] != 0) && (req_cnt == wait_tbl[ext_addr[5:0]]);
    end

    // Scoreboard: {index, data, offset} per expected cache write
    logic [37:0] exp_q[$];
    logic [15:0] mdl_base = 16'h0;
    int wr_in_fill = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_rel = 0;
    int t0 = 0;

    always @(negedge clock) begin
        logic [37:0] e;
        if (reset_n) begin
            check("busy_vs_state", fill_busy, ext_rd | mem_we);
            check("rd_we_exclusive", ext_rd & mem_we, 1'b0);
            if (ext_rd) check("ext_addr", ext_addr, mdl_base + 16'(wr_in_fill));
            if (mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected actual=%0h/%0h required=no write",
                             mem_inst_addr, mem_inst_bus);
                end else begin
                    e = exp_q.pop_front();
                    checks--;
                    check("write", {mem_inst_addr, mem_inst_bus, mem_offset}, e);
                end
                wr_in_fill++;
            end
            if (fill_done) begin
                done_cnt++;
                last_rel = cyc - t0 + 1;
            end
            if (fill_error) begin
                err_cnt++;
                last_rel = cyc - t0 + 1;
            end
        end
    end

    // Line-level reference: word k succeeds if its ready arrives within TO REQ cycles
    // and then costs (wait + 1) cycles; done follows the last word, error follows TO waits.
    task automatic model_fill(input logic [15:0] base_raw, output int kind, output int at, output int nw);
        logic [15:0] b;
        int acc;
        b = base_raw & AMASK;
        acc = 0;
        kind = 1;
        nw = 0;
        at = 0;
        for (int k = 0; k < LW; k++) begin
            if (wait_tbl[k] == 0 || wait_tbl[k] > TO) begin
                kind = 2;
                at = acc + TO + 1;
                return;
            end
            exp_q.push_back({6'(k), (b + 16'(k)) ^ 16'hA5A5, b});
            acc += wait_tbl[k] + 1;
            nw++;
        end
        at = acc + 1;
    endtask

    // Driver tasks
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic start_fill(input logic [15:0] b);
        fill_req  = 1'b1;
        fill_base = b;
        @(posedge clock);
        #1;
        t0 = cyc;
        mdl_base = b & AMASK;
        wr_in_fill = 0;
        fill_req = 1'b0;
        @(negedge clock);
        #1;
    endtask

    task automatic wait_outcome(input int max_cyc, output int kind, output int at);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        kind = 0;
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (done_cnt != d0) begin kind = 1; at = last_rel; break; end
            if (err_cnt != e0) begin kind = 2; at = last_rel; break; end
        end
    endtask

    task automatic idle_check(input string tag);
        step();
        check({tag, "_state"}, dbg_state, 3'd0);
        check({tag, "_outs"}, {fill_busy, ext_rd, mem_we, fill_done, fill_error}, 5'b0);
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_ctl"}, {fill_busy, fill_done, fill_error, ext_rd, mem_we, mem_inst_addr, ext_addr}, 27'h0);
        check({tag, "_data"}, {mem_offset, mem_inst_bus}, 32'h0);
        check({tag, "_state"}, dbg_state, 3'd0);
    endtask

    typedef struct {
        logic [15:0] base;
        int          wait_c;
        int          stuck;
        logic [15:0] exp_off;
        int          exp_kind;
        int          exp_cyc;
        int          exp_nw;
    } vec_t;
    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int mk, mc, mn, kind, at, d0, e0;
        logic [15:0] b;
        bit found;

        // kind 1 = done, 2 = error; stuck = word index that never gets ready (-1 none)
        vt[0] = '{16'h1234, 1, -1, 16'h1200, 1, 129, 64};
        vt[1] = '{16'hFFC5, 3, -1, 16'hFFC0, 1, 257, 64};
        vt[2] = '{16'h0040, 1,  5, 16'h0040, 2,  19,  5};
        vt[3] = '{16'h7FFF, 8, -1, 16'h7FC0, 1, 577, 64};
        vt[4] = '{16'h0000, 2,  0, 16'h0000, 2,   9,  0};
        vt[5] = '{16'hABCD, 1, 63, 16'hABC0, 2, 135, 63};

        for (int k = 0; k < LW; k++) wait_tbl[k] = 1;
        fill_req = 1'b0;
        fill_base = 16'h0;
        fill_abort = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        zero_check("reset_held");
        reset_n = 1'b1;
        step();
        zero_check("reset_released");

        // Table-driven fills
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < LW; k++) wait_tbl[k] = (k == vt[v].stuck) ? 0 : vt[v].wait_c;
            model_fill(vt[v].base, mk, mc, mn);
            start_fill(vt[v].base);
            check($sformatf("vec%0d_offset", v), mem_offset, vt[v].exp_off);
            wait_outcome(2000, kind, at);
            check($sformatf("vec%0d_kind", v), kind, vt[v].exp_kind);
            check($sformatf("vec%0d_cycle", v), at, vt[v].exp_cyc);
            check($sformatf("vec%0d_writes", v), wr_in_fill, vt[v].exp_nw);
            check($sformatf("vec%0d_pending", v), exp_q.size(), 0);
            idle_check($sformatf("vec%0d_after", v));
            exp_q.delete();
        end

        // Abort together with ext_ready on word 10
        for (int k = 0; k < LW; k++) wait_tbl[k] = 1;
        model_fill(16'h2000, mk, mc, mn);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        d0 = done_cnt;
        e0 = err_cnt;
        start_fill(16'h2000);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ext_rd && ext_addr == 16'h200A) found = 1;
            else step();
        end
        check("abort_reach_word10", found, 1'b1);
        fill_abort = 1'b1;
        step();
        fill_abort = 1'b0;
        check("abort_state", dbg_state, 3'd0);
        check("abort_outs", {fill_busy, ext_rd, mem_we}, 3'b0);
        check("abort_no_capture", {mem_inst_addr, mem_inst_bus}, {6'd9, 16'h2009 ^ 16'hA5A5});
        repeat (6) step();
        check("abort_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'h0);
        check("abort_writes", wr_in_fill, 10);
        check("abort_pending", exp_q.size(), 0);
        exp_q.delete();

        // Second request mid-fill is ignored; a request held through DONE is taken after IDLE
        model_fill(16'h1234, mk, mc, mn);
        start_fill(16'h1234);
        repeat (29) step();
        fill_req = 1'b1;
        fill_base = 16'h4000;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (fill_done) found = 1;
        end
        check("hold_done_seen", found, 1'b1);
        check("hold_done_cycle", last_rel, 129);
        check("hold_offset_kept", mem_offset, 16'h1200);
        check("hold_pending", exp_q.size(), 0);
        step();
        check("hold_idle_gap", {fill_busy, ext_rd}, 2'b00);
        check("hold_offset_idle", mem_offset, 16'h1200);
        model_fill(16'h4000, mk, mc, mn);
        start_fill(16'h4000);
        check("second_rd", ext_rd, 1'b1);
        check("second_offset", mem_offset, 16'h4000);
        wait_outcome(2000, kind, at);
        check("second_kind", kind, 1);
        check("second_cycle", at, 129);
        idle_check("second_after");
        exp_q.delete();

        // Reset in the middle of word 20, then a clean refill
        model_fill(16'h3000, mk, mc, mn);
        start_fill(16'h3000);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ext_rd && ext_addr == 16'h3014) found = 1;
            else step();
        end
        check("reset_reach_word20", found, 1'b1);
        check("reset_writes_before", wr_in_fill, 20);
        reset_n = 1'b0;
        #1;
        zero_check("reset_mid");
        exp_q.delete();
        step();
        step();
        reset_n = 1'b1;
        step();
        zero_check("reset_after");
        model_fill(16'h3000, mk, mc, mn);
        start_fill(16'h3000);
        wait_outcome(2000, kind, at);
        check("refill_kind", kind, 1);
        check("refill_cycle", at, 129);
        check("refill_writes", wr_in_fill, 64);
        check("refill_pending", exp_q.size(), 0);
        idle_check("refill_after");
        exp_q.delete();

        // Randomised fills against the model
        for (int r = 0; r < 5; r++) begin
            b = 16'($urandom_range(0, 65535));
            for (int k = 0; k < LW; k++) wait_tbl[k] = $urandom_range(1, TO);
            if ($urandom_range(0, 2) == 0) wait_tbl[$urandom_range(0, LW - 1)] = 0;
            model_fill(b, mk, mc, mn);
            start_fill(b);
            check($sformatf("rnd%0d_offset", r), mem_offset, b & AMASK);
            wait_outcome(2000, kind, at);
            check($sformatf("rnd%0d_kind", r), kind, mk);
            check($sformatf("rnd%0d_cycle", r), at, mc);
            check($sformatf("rnd%0d_writes", r), wr_in_fill, mn);
            check($sformatf("rnd%0d_pending", r), exp_q.size(), 0);
            idle_check($sformatf("rnd%0d_after", r));
            exp_q.delete();
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
